// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude compare sequencer: walks two operands MSB-first through an
// external 1-bit comparator. Optional early exit on first difference: SERIAL_CMP_EARLY_EXIT_EN.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_f1,
  input  logic             cmp_f2,
  input  logic             cmp_f3,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             pend_gt;
  logic             pend_lt;

  logic one_hot;
  logic decided_n;
  logic pend_gt_n;
  logic pend_lt_n;
  logic err_n;
  logic scan_exit;

  // Comparator is fed straight from the operand registers while scanning.
  assign cmp_a = (state == SCAN) ? a_r[idx] : 1'b0;
  assign cmp_b = (state == SCAN) ? b_r[idx] : 1'b0;

  // Fold the current comparator sample into the running decision.
  always_comb begin
    one_hot   = 1'b0;
    decided_n = decided;
    pend_gt_n = pend_gt;
    pend_lt_n = pend_lt;
    err_n     = err;
    scan_exit = 1'b0;
    case ({cmp_f1, cmp_f2, cmp_f3})
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
    if (!one_hot) begin
      err_n     = 1'b1;
      decided_n = 1'b1;
    end else if (!decided) begin
      if (cmp_f1) begin
        pend_gt_n = 1'b1;
        decided_n = 1'b1;
      end else if (cmp_f3) begin
        pend_lt_n = 1'b1;
        decided_n = 1'b1;
      end
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    scan_exit = (idx == '0) || decided_n;
`else
    scan_exit = (idx == '0);
`endif
  end

  // Sequencer: operand capture, per-bit scan, result load and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      pend_gt <= 1'b0;
      pend_lt <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= IDX_W'(WIDTH - 1);
            decided <= 1'b0;
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          decided <= decided_n;
          pend_gt <= pend_gt_n;
          pend_lt <= pend_lt_n;
          err     <= err_n;
          if (scan_exit) begin
            gt    <= pend_gt_n && !err_n;
            lt    <= pend_lt_n && !err_n;
            eq    <= !pend_gt_n && !pend_lt_n && !err_n;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl with a behavioural 1-bit comparator
// that can be forced non-one-hot at bit 5.
module tb_serial_compare_ctrl;

  localparam int unsigned WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cmp_a;
  logic       cmp_b;
  logic       cmp_f1;
  logic       cmp_f2;
  logic       cmp_f3;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       err;

  logic stub_en;
  logic stub_hit;
  int   sbit = 7;
  int   cyc  = 0;

  typedef struct {
    int    gt;
    int    eq;
    int    lt;
    int    err;
    int    done_cyc;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cmp_a  (cmp_a),
    .cmp_b  (cmp_b),
    .cmp_f1 (cmp_f1),
    .cmp_f2 (cmp_f2),
    .cmp_f3 (cmp_f3),
    .busy   (busy),
    .done   (done),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .err    (err)
  );

  // Comparator model; the stub drives an illegal f1=f3=1 while bit 5 is presented.
  assign stub_hit = stub_en && busy && (sbit == 5);
  assign cmp_f1   = stub_hit ? 1'b1 : (cmp_a & ~cmp_b);
  assign cmp_f2   = stub_hit ? 1'b0 : (cmp_a ~^ cmp_b);
  assign cmp_f3   = stub_hit ? 1'b1 : (~cmp_a & cmp_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    sbit <= busy ? sbit - 1 : 7;
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  function automatic int pick_lat(input int lat_on, input int lat_off);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return lat_on;
`else
    return lat_off;
`endif
  endfunction

  task automatic push_exp(input int egt, input int eeq, input int elt, input int eerr,
                          input int lat_on, input int lat_off, input string nm);
    exp_t e;
    e.gt       = egt;
    e.eq       = eeq;
    e.lt       = elt;
    e.err      = eerr;
    e.done_cyc = cyc + pick_lat(lat_on, lat_off);
    e.name     = nm;
    exp_q.push_back(e);
  endtask

  // Issue one operation from IDLE; expectations are pushed on the negedge after E0.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                       input int egt, input int eeq, input int elt, input int eerr,
                       input int lat_on, input int lat_off, input string nm);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_exp(egt, eeq, elt, eerr, lat_on, lat_off, nm);
    chk({nm, "_busy"}, int'(busy), 1);
    chk({nm, "_clr"}, int'({gt, eq, lt, err}), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy && !done) return;
      @(negedge clk);
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    stub_en = 1'b0;

    // Monitor: every done pulse is matched against the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_gt"}, int'(gt), e.gt);
            chk({e.name, "_eq"}, int'(eq), e.eq);
            chk({e.name, "_lt"}, int'(lt), e.lt);
            chk({e.name, "_err"}, int'(err), e.err);
            chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
            chk({e.name, "_busy_low"}, int'(busy), 0);
          end
        end
      end
    join_none

    #1;
    chk("reset_outputs", int'({busy, done, gt, eq, lt, err, cmp_a, cmp_b}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(8'h5A, 8'h5A, 0, 1, 0, 0, 8, 8, "eq_5a");
    wait_idle();
    issue(8'h80, 8'h7F, 1, 0, 0, 0, 1, 8, "gt_msb");
    wait_idle();
    issue(8'h12, 8'h13, 0, 0, 1, 0, 8, 8, "lt_lsb");
    wait_idle();
    issue(8'h00, 8'hFF, 0, 0, 1, 0, 1, 8, "lt_00_ff");
    wait_idle();

    // start held high through SCAN/DONE with new operands: ignored until IDLE.
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    @(negedge clk);
    push_exp(0, 0, 1, 0, 7, 8, "hold_first");
    a    = 8'hFF;
    b    = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("hold_first_seen", int'(seen), 1);
    @(negedge clk);
    chk("hold_idle_gap", int'({busy, done}), 0);
    @(negedge clk);
    start = 1'b0;
    push_exp(1, 0, 0, 0, 1, 8, "hold_second");
    chk("hold_second_busy", int'(busy), 1);
    wait_idle();

    // Asynchronous reset in the middle of a scan of all-ones operands.
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_cmp_a", int'(cmp_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_outputs", int'({busy, done, gt, eq, lt, err, cmp_a, cmp_b}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'h03, 8'h03, 0, 1, 0, 0, 8, 8, "post_reset_eq");
    wait_idle();

    // Non-one-hot comparator response at bit 5, then err must clear on next start.
    stub_en = 1'b1;
    issue(8'h5A, 8'h5A, 0, 0, 0, 1, 3, 8, "stub_err");
    wait_idle();
    stub_en = 1'b0;
    issue(8'h3C, 8'hC3, 0, 0, 1, 0, 1, 8, "after_err");
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
